// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the instruction-fetch
//            and data-access ports of the core. Grants one request at a time,
//            round-robin on contention, holds the memory request until
//            m_ready and returns a one-cycle ack with the read data.
// Options  : MEM_ARB_TIMEOUT_EN - adds a watchdog that forces completion with
//            err=1 after TIMEOUT_CYCLES stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_BITS      = 6,
  parameter int DATA_BITS      = 64,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // instruction fetch port
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_ack,
  // data port
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic [DATA_BITS-1:0] d_rdata,
  output logic                 d_ack,
  // memory side
  output logic                 m_req,
  output logic                 m_we,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic [DATA_BITS-1:0] m_wdata,
  input  logic [DATA_BITS-1:0] m_rdata,
  input  logic                 m_ready,
  // status
  output logic                 busy,
  output logic                 err
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_I_ACC = 2'd1;
  localparam logic [1:0] C_D_ACC = 2'd2;

  localparam logic C_GNT_I = 1'b0;
  localparam logic C_GNT_D = 1'b1;

  logic [1:0]           state_q,      state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 m_req_q,      m_req_d;
  logic                 m_we_q,       m_we_d;
  logic [ADDR_BITS-1:0] m_addr_q,     m_addr_d;
  logic [DATA_BITS-1:0] m_wdata_q,    m_wdata_d;
  logic                 i_ack_q,      i_ack_d;
  logic                 d_ack_q,      d_ack_d;
  logic [31:0]          i_rdata_q,    i_rdata_d;
  logic [DATA_BITS-1:0] d_rdata_q,    d_rdata_d;

  logic w_grant_i;
  logic w_grant_d;
  logic w_timeout;

  // A lone request wins; on contention the port that was not served last wins.
  assign w_grant_i = i_req & (~d_req | (last_grant_q == C_GNT_D));
  assign w_grant_d = d_req & ~w_grant_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                 C_TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TMR_W-1:0] C_TMR_LIMIT = C_TMR_W'(TIMEOUT_CYCLES);

  logic [C_TMR_W-1:0] tmr_q, tmr_d;
  logic               err_q, err_d;

  // The watchdog fires on the stalled cycle after the count has reached the limit.
  assign w_timeout = (state_q != C_IDLE) && (tmr_q == C_TMR_LIMIT);

  // Stall counter: cleared on grant, advanced on every stalled access cycle.
  always_comb begin
    tmr_d = tmr_q;
    err_d = 1'b0;
    if (state_q == C_IDLE) begin
      if (w_grant_i || w_grant_d) begin
        tmr_d = '0;
      end
    end else if (!m_ready) begin
      if (w_timeout) begin
        err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + C_TMR_W'(1);
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without the watchdog the limit has no effect.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state logic: grant from IDLE, hold the transfer until m_ready (or timeout).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      C_IDLE: begin
        // m_ready is deliberately ignored here.
        if (w_grant_i) begin
          state_d      = C_I_ACC;
          last_grant_d = C_GNT_I;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
        end else if (w_grant_d) begin
          state_d      = C_D_ACC;
          last_grant_d = C_GNT_D;
          m_req_d      = 1'b1;
          m_we_d       = d_we;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
        end
      end

      C_I_ACC, C_D_ACC: begin
        // m_ready takes priority over a timeout in the same cycle.
        if (m_ready || w_timeout) begin
          state_d = C_IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == C_I_ACC) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_ready ? m_rdata[31:0] : 32'd0;
          end else begin
            d_ack_d = 1'b1;
            if (!m_ready) begin
              d_rdata_d = '0;
            end else if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
          end
        end
      end

      default: begin
        state_d = C_IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      last_grant_q <= C_GNT_I;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != C_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios with
//            literal expectations, then randomized traffic against a
//            transaction-level model and a golden memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 64;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;
  logic          busy;
  logic          err;

  mem_port_arbiter #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory contents seen by the memory side, and what the requesters expect
  logic [DW-1:0] mem  [64];
  logic [DW-1:0] gold [64];

  // transaction-level model: who owns the memory, who was served last
  int            owner;       // 0 none, 1 fetch, 2 data
  int            last_served; // 1 fetch, 2 data
  int            stalls;
  logic          cur_we;
  logic          e_mreq, e_mwe, e_iack, e_dack, e_busy, e_err;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwdata, e_drdata;
  logic [31:0]   e_irdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = 0; last_served = 1; stalls = 0; cur_we = 1'b0;
    e_mreq = 0; e_mwe = 0; e_iack = 0; e_dack = 0; e_busy = 0; e_err = 0;
    e_maddr = '0; e_mwdata = '0; e_drdata = '0; e_irdata = '0;
  endtask

  task automatic model_finish(input bit timed_out);
    e_mreq = 0;
    e_mwe  = 0;
    e_err  = timed_out;
    if (owner == 1) begin
      e_iack   = 1;
      e_irdata = timed_out ? 32'd0 : m_rdata[31:0];
    end else begin
      e_dack = 1;
      if (timed_out)    e_drdata = '0;
      else if (!cur_we) e_drdata = m_rdata;
    end
    owner = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int want;
    e_iack = 0; e_dack = 0; e_err = 0;
    if (owner == 0) begin
      want = 0;
      if (i_req && d_req) want = (last_served == 1) ? 2 : 1;
      else if (i_req)     want = 1;
      else if (d_req)     want = 2;
      if (want != 0) begin
        owner = want; last_served = want; stalls = 0; e_mreq = 1;
        if (want == 1) begin
          e_maddr = i_addr; e_mwe = 0; cur_we = 0;
        end else begin
          e_maddr = d_addr; e_mwe = d_we; cur_we = d_we; e_mwdata = d_wdata;
        end
      end
    end else if (m_ready) begin
      model_finish(1'b0);
    end else begin
      stalls++;
`ifdef MEM_ARB_TIMEOUT_EN
      if (stalls > TO) model_finish(1'b1);
`endif
    end
    e_busy = (owner != 0);
  endtask

  task automatic compare_all();
    chk("m_req",   m_req,   e_mreq);
    chk("m_we",    m_we,    e_mwe);
    chk("m_addr",  m_addr,  e_maddr);
    chk("m_wdata", m_wdata, e_mwdata);
    chk("i_ack",   i_ack,   e_iack);
    chk("d_ack",   d_ack,   e_dack);
    chk("i_rdata", i_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    chk("busy",    busy,    e_busy);
    chk("err",     err,     e_err);
  endtask

  // memory macro: returns the addressed word during a read access
  task automatic drive_mem();
    if (m_req && !m_we) m_rdata = mem[m_addr];
    else                m_rdata = {$urandom, $urandom};
  endtask

  // One clock: inputs are already set at the falling edge; compare at the next one.
  task automatic tick();
    if (rst_n && m_req && m_ready && m_we) mem[m_addr] = m_wdata;
    if (!rst_n) model_reset();
    else        model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    drive_mem();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"},   m_req,   0);
    chk({tag, "_m_addr"},  m_addr,  0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_acks"},    {i_ack, d_ack, m_we, busy, err}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n, istall;
    int order[$];
    int exp_order[4];
    exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 1;

    for (int k = 0; k < 64; k++) begin
      mem[k]  = {$urandom, $urandom};
      gold[k] = mem[k];
    end
    rst_n = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; m_rdata = '0; m_ready = 0;
    #3 rst_n = 0;
    model_reset();

    // reset state
    @(negedge clk);
    chk_all_zero("reset");
    compare_all();
    tick();
    rst_n = 1;
    drive_mem();

    // m_ready while idle is ignored
    m_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_ready_mreq", {m_req, busy, i_ack, d_ack}, 0);
    end

    // single fetch, zero wait states
    mem[5] = 64'hAAAA_BBBB_0000_0013; gold[5] = mem[5];
    i_req = 1; i_addr = 6'd5; m_ready = 1;
    tick();
    chk("fetch_grant", {m_req, m_we, i_ack}, 3'b100);
    chk("fetch_addr", m_addr, 5);
    tick();
    chk("fetch_ack", i_ack, 1);
    chk("fetch_data", i_rdata, 32'h0000_0013);
    i_req = 0;
    tick();
    chk("fetch_ack_pulse", i_ack, 0);

    // store with three wait states
    d_req = 1; d_we = 1; d_addr = 6'd9; d_wdata = 64'h1234; m_ready = 0;
    hi = 0;
    tick();
    chk("store_we", m_we, 1);
    chk("store_wdata", m_wdata, 64'h1234);
    if (m_req) hi++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (m_req) hi++;
    end
    chk("store_no_early_ack", d_ack, 0);
    m_ready = 1;
    tick();
    chk("store_ack", d_ack, 1);
    chk("store_mreq_cycles", hi, 4);
    d_req = 0; m_ready = 0; gold[9] = 64'h1234;
    tick();
    chk("store_mem", mem[9], 64'h1234);

    // reset in the middle of a data read
    d_req = 1; d_we = 0; d_addr = 6'd3; m_ready = 0;
    tick();
    tick();
    chk("abort_pre_mreq", m_req, 1);
    #2 rst_n = 0;
    #1 chk_all_zero("abort");
    model_reset();
    d_req = 0;
    @(negedge clk);
    rst_n = 1;
    drive_mem();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_ack", {d_ack, m_req}, 0);
    end

    // contention: both held high, served D,I,D,I after reset
    i_req = 1; i_addr = 6'd7; d_req = 1; d_we = 0; d_addr = 6'd8; m_ready = 1;
    n = 0;
    while (order.size() < 4 && n < 20) begin
      tick();
      n++;
      if (i_ack && d_ack) chk("cont_overlap", {i_ack, d_ack}, 2'b00);
      if (d_ack) order.push_back(2);
      if (i_ack) order.push_back(1);
    end
    i_req = 0; d_req = 0;
    chk("cont_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk("cont_order", order[k], exp_order[k]);
    tick();

    // randomized traffic
    istall = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (i_req && i_ack) begin
        chk("rand_fetch_data", i_rdata, gold[i_addr][31:0]);
        i_req = 0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = AW'($urandom);
      end
      if (d_req && d_ack) begin
        if (d_we) gold[d_addr] = d_wdata;
        else      chk("rand_load_data", d_rdata, gold[d_addr]);
        d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = AW'($urandom);
        d_wdata = {$urandom, $urandom};
      end
      if (istall >= 5) m_ready = 1;
      else             m_ready = 1'($urandom);
      if (m_req && !m_ready) istall++;
      else                   istall = 0;
      tick();
    end

    // drain
    i_req = 0; d_req = 0; m_ready = 1;
    n = 0;
    while ((busy || i_ack || d_ack) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_idle", busy, 0);
    m_ready = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog: memory never answers a data read
    d_req = 1; d_we = 0; d_addr = 6'd2; m_ready = 0;
    tick();
    d_req = 0;
    n = 0;
    while (!d_ack && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_edges", n, 16);
    chk("timeout_err", {d_ack, err}, 2'b11);
    chk("timeout_data", d_rdata, 0);
    chk("timeout_idle", busy, 0);
    tick();
    chk("timeout_err_pulse", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
